ifu_prefetch: RTL
=================

# ifu_prefetch

Parametrised instruction-fetch unit that replaces the single-register PC stage between the instruction ROM and the decoder. It keeps fetching sequential addresses ahead of decode into a DEPTH-entry prefetch FIFO, presents instructions to decode through a valid/ready handshake, and flushes on a redirect from execute. It sits between the instruction ROM port and the `id` stage of the core top.

## Interface
- `XLEN`, 32: address and PC width.
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.
- `DEPTH`, 4: prefetch FIFO entries; must be a power of two and at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `ifu_instrom_addr` out XLEN: ROM fetch address, word-aligned.
- `ifu_instrom_ren` out 1: ROM read enable.
- `instrom_ifu_data` in 32: ROM data, valid the cycle after `ren`.
- `ex_ifu_redirect_wen` in 1: execute-stage redirect (branch, jump or trap).
- `ex_ifu_redirect_pc` in XLEN: redirect target; bits [1:0] are ignored and treated as 0.
- `ifu_id_valid` out 1: head instruction available.
- `ifu_id_inst` out 32: head instruction; 32'h0000_0013 (NOP) when not valid.
- `ifu_id_pc` out XLEN: PC of the head instruction; 0 when not valid.
- `id_ifu_ready` in 1: decode accepts this cycle. A transfer occurs when `valid` and `ready` are both high.

## Operation
State:
- `fpc`: next fetch PC.
- `pending` (1 bit) with `pending_pc`: one request in flight.
- FIFO of {pc, inst}: `rd_ptr`, `wr_ptr`, `count` (width log2(DEPTH)+1).

Reset:
- `fpc` = `RESET_PC`; `pending` = 0; FIFO empty.
- `ren` = 0, `valid` = 0, `inst` = NOP, `pc` = 0.

Request issue:
- `pop` = `valid` & `ready` & !redirect.
- `ren` = redirect | (!rst & (`count` + `pending` − `pop` < `DEPTH`)).
- `addr` = redirect ? {`redirect_pc`[XLEN-1:2], 2'b00} : `fpc`.
- When `ren` is high: `fpc` <= `addr` + 4 (XLEN-bit wrap), `pending` <= 1, `pending_pc` <= `addr`. Otherwise `pending` <= 0.

Response:
- When `pending` is set and there is no redirect, {`pending_pc`, `instrom_ifu_data`} is pushed at `wr_ptr`.
- Space is guaranteed by the issue rule, so a push into a full FIFO never happens.
- Push and pop in the same cycle leave `count` unchanged. Pointers wrap modulo `DEPTH`.

Redirect (`ex_ifu_redirect_wen` = 1), which has priority over every other event:
- FIFO is flushed (`count`, `rd_ptr`, `wr_ptr` <= 0).
- Any in-flight response arriving this cycle is discarded.
- `ifu_id_valid` is forced to 0 this cycle, so no transfer occurs.
- A new request to the target is issued in the same cycle.

## Timing
- Without bypass: request in cycle N, push at the end of N+1, `valid` in N+2 (2-cycle fetch-to-decode).
- Steady state with `ready` held high: one instruction per cycle for any `DEPTH` >= 2.
- Redirect in cycle R: the target's request is issued in R, its data arrives in R+1, and it is visible to decode in R+2 (R+1 with bypass).
- `ready` low: fetch stops once `count` + `pending` = `DEPTH`. No instruction is lost or duplicated.
- Asynchronous `rst` mid-operation clears all state immediately. The first request (`addr` = `RESET_PC`) is issued in the first cycle after deassertion.
- `ifu_id_*` are combinational from FIFO head state, plus `redirect` (and, with bypass, the response path).

## Configuration
- `IFU_BYPASS_EN` defined:
  - When the FIFO is empty and a response arrives with no redirect, it drives `ifu_id_*` in the same cycle with `valid` = 1.
  - If `ready` is also high, the instruction is consumed without being written to the FIFO.
  - `pop` includes this bypass transfer.
- `IFU_BYPASS_EN` undefined: every response goes through the FIFO, and `valid` depends only on registered state (plus `redirect`).

## Test plan
- Reset, `ready` = 1 → addresses 0x8000_0000, 0x8000_0004, 0x8000_0008… on consecutive cycles; decode receives matching pc/inst pairs, one per cycle after the 2-cycle fill (1 with bypass).
- `ready` = 0 from reset, `DEPTH` = 4 → exactly 4 requests issued, `ren` stays 0 afterward; raising `ready` drains 0x8000_0000..0x8000_000C in order, then fetch resumes at 0x8000_0010.
- Redirect to 0x8000_0102 while FIFO holds 3 entries and a request is in flight → `valid` = 0 that cycle, `addr` = 0x8000_0100; the next instruction delivered has pc 0x8000_0100, and no older entry appears.
- Redirect in the same cycle as a response and `ready` = 1 → response dropped, no transfer, `count` = 0 next cycle.
- `fpc` = 0xFFFF_FFFC → next address is 0x0000_0000 (wrap).
- `rst` asserted with FIFO full → `valid` = 0 and `ren` = 0 immediately; after release the fetch sequence restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetch into a DEPTH-entry FIFO feeding decode, flushed on redirect.
// Optional IFU_BYPASS_EN: hands a response straight to decode while the FIFO is empty.
module ifu_prefetch #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] ifu_instrom_addr,
  output logic            ifu_instrom_ren,
  input  logic [31:0]     instrom_ifu_data,
  input  logic            ex_ifu_redirect_wen,
  input  logic [XLEN-1:0] ex_ifu_redirect_pc,
  output logic            ifu_id_valid,
  output logic [31:0]     ifu_id_inst,
  output logic [XLEN-1:0] ifu_id_pc,
  input  logic            id_ifu_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [XLEN-1:0] fpc, pending_pc;
  logic            pending;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic            redirect, empty, byp, pop, push, fifo_pop;
  logic [AW+1:0]   occ;
  assign redirect = ex_ifu_redirect_wen;
  assign empty = count == '0;
`ifdef IFU_BYPASS_EN
  assign byp = empty & pending & !redirect;
`else
  assign byp = 1'b0;
`endif
  assign ifu_id_valid = (!empty | byp) & !redirect;
  assign ifu_id_pc = !ifu_id_valid ? '0 : byp ? pending_pc : pc_mem[rd_ptr];
  assign ifu_id_inst = !ifu_id_valid ? NOP : byp ? instrom_ifu_data : inst_mem[rd_ptr];
  assign pop = ifu_id_valid & id_ifu_ready & !redirect;
  assign fifo_pop = pop & !byp;
  assign push = pending & !redirect & !(byp & id_ifu_ready);
  // occupancy the FIFO will have once the in-flight response lands, net of this cycle's pop
  assign occ = (AW+2)'(count) + (AW+2)'(pending) - (AW+2)'(pop);
  assign ifu_instrom_ren = redirect | (!rst & (occ < (AW+2)'(DEPTH)));
  assign ifu_instrom_addr = redirect ? {ex_ifu_redirect_pc[XLEN-1:2], 2'b00} : fpc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc <= RESET_PC;
      pending <= 1'b0;
      pending_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      pending <= ifu_instrom_ren;
      if (ifu_instrom_ren) begin
        fpc <= ifu_instrom_addr + XLEN'(4);
        pending_pc <= ifu_instrom_addr;
      end
      rd_ptr <= redirect ? '0 : rd_ptr + AW'(fifo_pop);
      wr_ptr <= redirect ? '0 : wr_ptr + AW'(push);
      count <= redirect ? '0 : count + (AW+1)'(push) - (AW+1)'(fifo_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= pending_pc;
      inst_mem[wr_ptr] <= instrom_ifu_data;
    end
  end
endmodule
